bcd_conversion_scheduler: RTL

//  - Shares one sequential binary-to-BCD converter between N requesters.
//  - The converter counts to the value, so its latency is value-dependent.
//  - Round-robin arbitration, one conversion in flight, result returned with requester ID

---
 rtl/bcd_conversion_scheduler_pkg.sv | 22 ++
 rtl/bcd_conversion_scheduler_rr_arbiter.sv | 46 ++++
 rtl/bcd_conversion_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bcd_conversion_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// bcd_sched_pkg
// Shared types and constants for the BCD conversion scheduler.
//   state_t     : scheduler FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   BCD_DIGITS  : number of BCD digits returned by the converter
//   BCD_W       : width of a packed BCD result
//   TIMEOUT_BCD : result reported when a conversion is abandoned on timeout
// -----------------------------------------------------------------------------
package bcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int              BCD_DIGITS  = 4;
    localparam int              BCD_W       = BCD_DIGITS * 4;
    localparam logic [BCD_W-1:0] TIMEOUT_BCD = 16'hFFFF;

endpackage

// File: rtl/bcd_conversion_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: grants the first requester at or above
// the pointer, wrapping modulo N_REQ.
// Ports:
//   i_req        in   N_REQ  request vector
//   i_ptr        in   IDW    highest-priority index (0..N_REQ-1)
//   o_grant      out  N_REQ  one-hot grant (all zero when no request)
//   o_grant_idx  out  IDW    index of the granted requester
//   o_any_req    out  1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDW-1:0]   o_grant_idx,
    output logic             o_any_req
);

    logic [IDW:0] w_idx;
    logic         w_found;

    assign o_any_req = |i_req;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        // Walk the rotation ptr, ptr+1, ... and keep the first hit.
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, i_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(N_REQ))
                w_idx = w_idx - (IDW+1)'(N_REQ);
            if (!w_found && i_req[w_idx[IDW-1:0]]) begin
                w_found     = 1'b1;
                o_grant_idx = w_idx[IDW-1:0];
            end
        end
        o_grant[o_grant_idx] = w_found;
    end

endmodule

// File: rtl/bcd_conversion_scheduler.sv
// -----------------------------------------------------------------------------
// bcd_conversion_scheduler
// Shares one sequential binary-to-BCD converter between N_REQ requesters.
// Round-robin arbitration, one conversion in flight, result returned with the
// owning requester ID over a valid/ready handshake.
// Optional feature macro: BCD_SCHED_TIMEOUT_EN (WAIT-state watchdog; when
// undefined the scheduler waits indefinitely and timeout_err is constant 0).
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   req_valid      N_REQ    requester i has a value pending
//   req_value      N_REQ*W  packed values, requester i at [i*W +: W]
//   req_ready      N_REQ    one-hot 1-cycle accept pulse
//   conv_start     1        1-cycle start pulse to converter
//   conv_value     W        value under conversion, stable until done
//   conv_done      1        converter result valid
//   conv_bcd       16       converter BCD result
//   rsp_valid/rsp_id/rsp_bcd/rsp_ready  result handshake
//   timeout_err    1        sticky watchdog flag
// -----------------------------------------------------------------------------
module bcd_conversion_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 10,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_value,
    output logic [N_REQ-1:0]   req_ready,
    output logic               conv_start,
    output logic [W-1:0]       conv_value,
    input  logic               conv_done,
    input  logic [BCD_W-1:0]   conv_bcd,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [BCD_W-1:0]   rsp_bcd,
    input  logic               rsp_ready,
    output logic               timeout_err
);

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [N_REQ-1:0]   r_req_ready;
    logic               r_conv_start;
    logic [W-1:0]       r_conv_value;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [BCD_W-1:0]   r_rsp_bcd;

    logic [N_REQ-1:0]   w_grant;
    logic [IDW-1:0]     w_gidx;
    logic               w_any;
    logic [W-1:0]       w_sel_value;
    logic [IDW-1:0]     w_next_ptr;

`ifdef BCD_SCHED_TIMEOUT_EN
    // Last WAIT cycle count before giving up: 2**W+4 cycles spent in WAIT.
    localparam logic [W+1:0] TO_LAST = (W+2)'(2**W + 3);
    logic [W+1:0]       r_wait_cnt;
    logic               r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any_req   (w_any)
    );

    always_comb begin
        w_sel_value = '0;
        for (int i = 0; i < N_REQ; i++)
            if (w_gidx == IDW'(i))
                w_sel_value = req_value[i*W +: W];
    end

    // Pointer wraps explicitly so non-power-of-two N_REQ works.
    assign w_next_ptr = (w_gidx == IDW'(N_REQ-1)) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_req_ready  <= '0;
            r_conv_start <= 1'b0;
            r_conv_value <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_bcd    <= '0;
`ifdef BCD_SCHED_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_req_ready  <= '0;
            r_conv_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_req_ready  <= w_grant;
                        r_conv_value <= w_sel_value;
                        r_rsp_id     <= w_gidx;
                        r_ptr        <= w_next_ptr;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_conv_start <= 1'b1;
`ifdef BCD_SCHED_TIMEOUT_EN
                    r_wait_cnt   <= '0;
`endif
                    r_state      <= WAIT;
                end
                WAIT: begin
                    // A done coinciding with our own start pulse is spurious.
                    if (conv_done && !r_conv_start) begin
                        r_rsp_bcd   <= conv_bcd;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
`ifdef BCD_SCHED_TIMEOUT_EN
                    else if (r_wait_cnt == TO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_rsp_bcd     <= TIMEOUT_BCD;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign conv_start = r_conv_start;
    assign conv_value = r_conv_value;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_bcd    = r_rsp_bcd;

endmodule
